ccff_readback_ctrl: RTL and testbench

- Readback side of the configuration-chain (CCFF) protocol: shifts the bits out of `ccff_tail` and packs them into parallel words.
- Presents each word on a valid/ready interface for the bench or the host-side debug port.
- Drives the chain's shift enable and head input, so readback can be destructive (zero-fill) or non-destructive (recirculate).
- Sits next to the fabric's configuration chain and runs on the programming clock.

---
 rtl/ccff_pkg.sv | 15 +
 rtl/ccff_word_packer.sv | 91 +++++++++
 rtl/ccff_readback_ctrl.sv | 111 +++++++++++
 tb/tb_ccff_readback_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
`default_nettype none
// ccff_pkg: state encoding and shared defaults for the CCFF loader/readback controllers (rev 1.0).
package ccff_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int CCFF_DEF_CHAIN_LEN = 64;
   localparam int CCFF_DEF_WORD_W    = 8;

endpackage
`default_nettype wire

// File: rtl/ccff_word_packer.sv
`default_nettype none
// ccff_word_packer: LSB-first serial-to-parallel collector with a one-deep valid/ready output register (rev 1.0).
module ccff_word_packer
   import ccff_pkg::*;
#(
   parameter int WORD_W = CCFF_DEF_WORD_W
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              clear,
   input  logic              active,
   input  logic              ins_en,
   input  logic              ins_bit,
   input  logic              at_end,
   input  logic              word_ready,
   output logic              stall,
   output logic              handoff,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   output logic              word_last
);

   localparam int COL_W = $clog2(WORD_W + 1);

   logic [WORD_W-1:0] collector_q, collector_d;
   logic [COL_W-1:0]  col_cnt_q, col_cnt_d;
   logic [WORD_W-1:0] word_data_q, word_data_d;
   logic              word_valid_q, word_valid_d;
   logic              word_last_q, word_last_d;

   logic col_full, out_free, want;

   always_comb begin
      col_full = (col_cnt_q == COL_W'(WORD_W));
      out_free = ~word_valid_q | word_ready;
      want     = active & (col_full | (at_end & (col_cnt_q != '0)));
      handoff  = want & out_free;
      stall    = active & col_full & ~out_free;

      collector_d  = collector_q;
      col_cnt_d    = col_cnt_q;
      word_data_d  = word_data_q;
      word_valid_d = word_valid_q;
      word_last_d  = word_last_q;

      if (word_valid_q & word_ready) begin
         word_valid_d = 1'b0;
         word_last_d  = 1'b0;
      end
      if (handoff) begin
         word_data_d  = collector_q;
         word_valid_d = 1'b1;
         word_last_d  = at_end;
         collector_d  = '0;
         col_cnt_d    = '0;
      end
      if (clear) begin
         collector_d = '0;
         col_cnt_d   = '0;
      end
      // Insertion uses the post-handoff count so a word can leave and the next bit land on one edge.
      if (ins_en) begin
         for (int i = 0; i < WORD_W; i++) begin
            if (col_cnt_d == COL_W'(i)) collector_d[i] = ins_bit;
         end
         col_cnt_d = col_cnt_d + COL_W'(1);
      end
   end

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         collector_q  <= '0;
         col_cnt_q    <= '0;
         word_data_q  <= '0;
         word_valid_q <= 1'b0;
         word_last_q  <= 1'b0;
      end else begin
         collector_q  <= collector_d;
         col_cnt_q    <= col_cnt_d;
         word_data_q  <= word_data_d;
         word_valid_q <= word_valid_d;
         word_last_q  <= word_last_d;
      end
   end

   assign word_data  = word_data_q;
   assign word_valid = word_valid_q;
   assign word_last  = word_last_q;

endmodule
`default_nettype wire

// File: rtl/ccff_readback_ctrl.sv
`default_nettype none
// ccff_readback_ctrl: shifts the configuration chain out of ccff_tail and presents it as valid/ready words,
// either recirculating the chain or zero-filling it (rev 1.0).
module ccff_readback_ctrl
   import ccff_pkg::*;
#(
   parameter int CHAIN_LEN = CCFF_DEF_CHAIN_LEN,
   parameter int WORD_W    = CCFF_DEF_WORD_W,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              start,
   input  logic              recirc,
   input  logic              ccff_tail,
   output logic              ccff_head,
   output logic              chain_shift_en,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              word_last,
   output logic              busy,
   output logic              done
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             recirc_q, recirc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic active, at_end, stall, handoff, shift_en, clear;

   assign active   = (state_q == SHIFT);
   assign at_end   = (bit_cnt_q == CNT_W'(CHAIN_LEN));
   assign shift_en = active & ~at_end & ~stall;

   assign chain_shift_en = shift_en;
   assign ccff_head      = shift_en & recirc_q & ccff_tail;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      recirc_d  = recirc_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      clear     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               recirc_d  = recirc;
               bit_cnt_d = '0;
               busy_d    = 1'b1;
               clear     = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (shift_en) bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (handoff & at_end) state_d = DRAIN;
         end
         DRAIN: begin
            if (word_valid & word_ready) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         recirc_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         recirc_q  <= recirc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;

   ccff_word_packer #(
      .WORD_W (WORD_W)
   ) u_packer (
      .prog_clk   (prog_clk),
      .pReset_n   (pReset_n),
      .clear      (clear),
      .active     (active),
      .ins_en     (shift_en),
      .ins_bit    (ccff_tail),
      .at_end     (at_end),
      .word_ready (word_ready),
      .stall      (stall),
      .handoff    (handoff),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_last  (word_last)
   );

endmodule
`default_nettype wire

// File: tb/tb_ccff_readback_ctrl.sv
`default_nettype none
// tb_ccff_readback_ctrl: three readback controllers (chain 16/20/5, word 8) driving modelled configuration chains.
module tb_ccff_readback_ctrl;

   logic        clk = 1'b0;
   logic        pReset_n;
   logic        st  [3];
   logic        rc  [3];
   logic        rdy [3];
   logic        ld  [3];
   logic [31:0] ld_val;
   logic        tl  [3];
   logic        hd  [3];
   logic        se  [3];
   logic [7:0]  wd  [3];
   logic        wv  [3];
   logic        wl  [3];
   logic        bz  [3];
   logic        dn  [3];
   logic [31:0] chain_o [3];
   logic [31:0] nsh_o   [3];

   int nassert = 0;
   int nfail   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 16 : ((g == 1) ? 20 : 5);
      logic [31:0] chain = '0;
      logic [31:0] nshift = '0;

      // Chain model: bit 0 is the tail, the head bit enters at position L-1.
      always @(posedge clk) begin
         if (ld[g]) begin
            chain  <= ld_val;
            nshift <= '0;
         end else if (se[g]) begin
            chain  <= (chain >> 1) | ({31'b0, hd[g]} << (L - 1));
            nshift <= nshift + 32'd1;
         end
      end
      assign tl[g]      = chain[0];
      assign chain_o[g] = chain;
      assign nsh_o[g]   = nshift;

      ccff_readback_ctrl #(
         .CHAIN_LEN (L),
         .WORD_W    (8)
      ) u_dut (
         .prog_clk       (clk),
         .pReset_n       (pReset_n),
         .start          (st[g]),
         .recirc         (rc[g]),
         .ccff_tail      (tl[g]),
         .ccff_head      (hd[g]),
         .chain_shift_en (se[g]),
         .word_data      (wd[g]),
         .word_valid     (wv[g]),
         .word_ready     (rdy[g]),
         .word_last      (wl[g]),
         .busy           (bz[g]),
         .done           (dn[g])
      );
   end

   function automatic int len_of(input int k);
      return (k == 0) ? 16 : ((k == 1) ? 20 : 5);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nassert++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input int k, input string tag);
      chk({tag, "_data"},  {24'b0, wd[k]}, 32'h0);
      chk({tag, "_flags"}, {26'b0, wv[k], wl[k], bz[k], dn[k], se[k], hd[k]}, 32'h0);
   endtask

   // mode 0: ready held high, 1: ready low for stall_n cycles after first valid, 2: random ready
   task automatic readback(input int k, input bit rcv, input logic [31:0] init_raw, input int mode,
                           input int stall_n, input int restart_at, input int reset_at);
      int          L          = len_of(k);
      logic [31:0] init       = init_raw & ((32'h1 << L) - 32'h1);
      int          nw         = (L + 7) / 8;
      int          first_exp  = ((L < 8) ? L : 8) + 1;
      int          widx       = 0;
      int          cyc        = 0;
      int          first_v    = -1;
      int          done_cyc   = -1;
      int          stall_left = stall_n;
      bit          pv         = 1'b0;
      logic [7:0]  pd         = '0;
      logic        pl         = 1'b0;
      logic [31:0] exp_word;

      @(negedge clk);
      ld_val = init;
      ld[k]  = 1'b1;
      @(negedge clk);
      ld[k]  = 1'b0;
      st[k]  = 1'b1;
      rc[k]  = rcv;
      rdy[k] = 1'b1;
      @(negedge clk);
      st[k]  = 1'b0;
      chk("busy_after_start", {31'b0, bz[k]}, 32'h1);

      while (cyc < 300) begin
         if (pv) begin
            chk("hold_valid", {31'b0, wv[k]}, 32'h1);
            chk("hold_data",  {24'b0, wd[k]}, {24'b0, pd});
            chk("hold_last",  {31'b0, wl[k]}, {31'b0, pl});
         end
         if (done_cyc >= 0) begin
            chk("done_one_cycle", {31'b0, dn[k]}, 32'h0);
            break;
         end
         if (dn[k]) begin
            done_cyc = cyc;
            chk("busy_at_done", {31'b0, bz[k]}, 32'h0);
         end
         if (wv[k] && first_v < 0) begin
            first_v = cyc;
            chk("first_valid_latency", first_v, first_exp);
         end

         if (mode == 0) begin
            rdy[k] = 1'b1;
         end else if (mode == 1) begin
            if (first_v >= 0 && stall_left > 0) begin
               if (stall_left == 1) chk("stall_shift_off", {31'b0, se[k]}, 32'h0);
               rdy[k] = 1'b0;
               stall_left--;
            end else begin
               rdy[k] = 1'b1;
            end
         end else begin
            rdy[k] = 1'($urandom_range(0, 1));
         end

         if (wv[k] && rdy[k]) begin
            exp_word = (init >> (8 * widx)) & 32'hFF;
            chk("word_data", {24'b0, wd[k]}, exp_word);
            chk("word_last", {31'b0, wl[k]}, (widx == nw - 1) ? 32'h1 : 32'h0);
            widx++;
         end
         pv = wv[k] & ~rdy[k];
         pd = wd[k];
         pl = wl[k];

         st[k] = (cyc == restart_at) ? 1'b1 : 1'b0;

         if (cyc == reset_at) begin
            pReset_n = 1'b0;
            st[k]    = 1'b0;
            #1;
            chk_idle_outputs(k, "async_reset");
            @(posedge clk);
            @(negedge clk);
            pReset_n = 1'b1;
            @(negedge clk);
            chk_idle_outputs(k, "after_reset");
            return;
         end

         @(negedge clk);
         cyc++;
      end

      chk("done_seen",   (done_cyc >= 0) ? 32'h1 : 32'h0, 32'h1);
      chk("word_count",  widx, nw);
      chk("shift_edges", nsh_o[k], L);
      chk("chain_after", chain_o[k], rcv ? init : 32'h0);
      if (mode == 0) chk("done_latency", done_cyc, L + 2);
      rdy[k] = 1'b1;
   endtask

   initial begin
      pReset_n = 1'b0;
      ld_val   = '0;
      for (int i = 0; i < 3; i++) begin
         st[i]  = 1'b0;
         rc[i]  = 1'b0;
         rdy[i] = 1'b1;
         ld[i]  = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) chk_idle_outputs(i, "reset_state");

      // start held while reset is asserted must not launch a readback
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      pReset_n = 1'b1;
      @(negedge clk);
      chk("start_during_reset", {31'b0, bz[0]}, 32'h0);

      readback(0, 1'b1, 32'h0000A5C3, 0, 0, -1, -1);
      readback(1, 1'b0, 32'h000F1234, 0, 0, -1, -1);
      readback(0, 1'b1, 32'h0000A5C3, 1, 12, -1, -1);
      readback(0, 1'b1, 32'h0000A5C3, 0, 0, 5, -1);
      readback(0, 1'b1, 32'h0000A5C3, 0, 0, -1, 5);
      readback(0, 1'b1, 32'h00005A3C, 0, 0, -1, -1);
      readback(2, 1'b0, 32'h0000000D, 0, 0, -1, -1);
      chk("single_word_value", 32'h0000000D & 32'hFF, 32'h0D);

      for (int n = 0; n < 8; n++) begin
         readback($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom, (n % 2 == 0) ? 2 : 0, 0, -1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

endmodule
`default_nettype wire
